alu_issue_seq: RTL and testbench
================================

// Module: alu_issue_seq
// PURPOSE
//  Instruction issue sequencer directly upstream of ALU_16Bit. Accepts 16-bit
//  instruction words over a valid/ready handshake, reads operands from a local
//  6x16 register file, drives ALU operand/control inputs, waits a fixed settle
//  time, then captures the ALU result and flags and writes back. One op in flight.
// PARAMETERS
//  SETTLE_CYC   4   cycles ALU inputs are held stable before capture (1..15)
//  NUM_REGS     6   register-file depth; indices >= NUM_REGS are illegal
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  in_valid     in   1   instruction word valid
//  in_instr     in   16  [15:13] opc, [12:10] rd, [9:7] rs1, [6:4] rs2; LDI: [9:0] imm
//  in_ready     out  1   high only in IDLE
//  alu_a        out  16  operand A to ALU
//  alu_b        out  16  operand B to ALU
//  alu_sub      out  1   1 for SUB only
//  alu_op       out  3   ALU op_select (0 ADD,1 SUB,2 AND,3 OR,4 MUL,5 DIV)
//  alu_result   in   16  ALU result
//  alu_cout     in   1   ALU carry out
//  alu_ovf      in   1   ALU overflow
//  alu_n        in   1   ALU negative flag
//  alu_z        in   1   ALU zero flag
//  wb_valid     out  1   one-cycle pulse: writeback/retire this cycle
//  wb_rd        out  3   destination index of retired op
//  wb_data      out  16  value written (0 when wb_err)
//  wb_err       out  1   op retired with error, no register write
//  flags        out  4   sticky {C,V,N,Z} of last successful ALU op
// BEHAVIOUR
//  Reset: state IDLE, all regs 0, alu_a/alu_b 0, alu_op 0, alu_sub 0, wb_* 0,
//   flags 0, in_ready 1 once rst drops. Reset mid-op aborts; no writeback.
//  Opcodes: 0-5 ALU ops; 6 LDI (rd <= {6'b0,imm10}, no ALU use); 7 NOP.
//  FSM: IDLE -(in_valid)-> DECODE -> EXEC -> WB -> IDLE.
//   IDLE:   accept when in_valid&in_ready; latch instr.
//   DECODE: check legality; read rs1/rs2; drive alu_a/b/op/sub (held through EXEC).
//           Illegal (rd/rs1/rs2 >= NUM_REGS for ALU ops, rd for LDI) or
//           DIV with rs2 value 0 -> go WB with error.
//           LDI and NOP skip EXEC.
//   EXEC:   counter runs SETTLE_CYC cycles; on last cycle capture result+flags.
//   WB:     wb_valid=1; write reg[rd] unless NOP or error; update flags only
//           for successful ALU ops (opc 0-5); NOP: wb_valid=1, wb_rd=0, no write.
//  Latency accept->wb_valid: ALU op SETTLE_CYC+2 cycles; LDI/NOP/error 2 cycles.
//  Back-to-back: in_ready returns 1 the cycle after WB; no overlap.
//  rd==rs1/rs2 allowed: operands read in DECODE, write in WB (no hazard).
//  Flags: C=alu_cout, V=alu_ovf; N,Z recomputed from captured result for ops 2-5,
//   taken from ALU for ops 0-1; C,V forced 0 for ops 2-5.
//  in_instr ignored when not accepted; in_valid may drop without penalty.
// STRUCTURE
//  Shared package alu_pkg: opcode constants (OP_ADD..OP_NOP), state encoding,
//   instruction field slice positions, NUM_REGS default.
//  One sub-module: alu_regfile (NUM_REGS x16, 2 async read, 1 sync write, async clr).
// TESTING
//  LDI r0=0x0005, LDI r1=0x0003, ADD r2=r0+r1 -> wb_data 0x0008, flags 4'b0000,
//   wb_valid exactly SETTLE_CYC+2 cycles after accept.
//  LDI r0=0, LDI r1=1, SUB r2=r0-r1 -> wb_data 0xFFFF, N=1, Z=0.
//  DIV r2=r0/r1 with r1=0 -> wb_err=1, wb_data 0, r2 unchanged, flags unchanged.
//  Instr with rd=7 -> wb_err=1 two cycles after accept; in_ready high next cycle.
//  Assert rst during EXEC of MUL -> all outputs 0 immediately, no wb_valid, regs 0.
//  in_valid held high with 3 queued instrs -> each accepted only in IDLE, in order.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcodes, FSM encoding and instruction field layout for the
//            ALU issue sequencer.
// Revision : 1.0 - initial release
// ============================================================================

package alu_pkg;

    localparam int NUM_REGS_DFLT = 6;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_DIV = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_WB     = 2'd3;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 4;
    localparam int IMM_MSB = 9;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [2:0] opc;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [9:0] imm;
    } instr_t;

    function automatic instr_t decode_instr(input logic [15:0] word);
        instr_t ins;
        ins.opc = word[OPC_MSB:OPC_LSB];
        ins.rd  = word[RD_MSB:RD_LSB];
        ins.rs1 = word[RS1_MSB:RS1_LSB];
        ins.rs2 = word[RS2_MSB:RS2_LSB];
        ins.imm = word[IMM_MSB:IMM_LSB];
        return ins;
    endfunction

    function automatic logic is_alu_op(input logic [2:0] opc);
        return opc <= OP_DIV;
    endfunction

    function automatic logic idx_ok(input logic [2:0] idx, input int depth);
        return int'(idx) < depth;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Brief    : NUM_REGS x 16 register file, two async reads, one sync write,
//            asynchronous clear. Out-of-range reads return 0.
// Revision : 1.0 - initial release
// ============================================================================

module alu_regfile
    import alu_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd,
    input  logic [2:0]  ra1,
    output logic [15:0] rd1,
    input  logic [2:0]  ra2,
    output logic [15:0] rd2
);

    logic [15:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && idx_ok(wa, NUM_REGS)) begin
            r_mem[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (idx_ok(ra1, NUM_REGS)) rd1 = r_mem[ra1];
        if (idx_ok(ra2, NUM_REGS)) rd2 = r_mem[ra2];
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_seq
// Brief    : Single-issue sequencer feeding a 16-bit ALU: decode, operand read,
//            settle wait, result capture and register writeback.
// Revision : 1.0 - initial release
// ============================================================================

module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int NUM_REGS   = NUM_REGS_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_sub,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_ovf,
    input  logic        alu_n,
    input  logic        alu_z,
    output logic        wb_valid,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        wb_err,
    output logic [3:0]  flags
);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    instr_t      r_instr;
    logic [3:0]  r_cnt;
    logic        r_err;
    logic [15:0] r_wb_data;
    logic [3:0]  r_flags_cap;
    logic [3:0]  r_flags;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [2:0]  r_alu_op;
    logic        r_alu_sub;

    logic [15:0] w_rs1_val;
    logic [15:0] w_rs2_val;
    logic        w_is_alu;
    logic        w_dec_err;
    logic        w_exec_last;
    logic        w_rf_we;
    logic [3:0]  w_flags_new;

    alu_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .we  (w_rf_we),
        .wa  (r_instr.rd),
        .wd  (r_wb_data),
        .ra1 (r_instr.rs1),
        .rd1 (w_rs1_val),
        .ra2 (r_instr.rs2),
        .rd2 (w_rs2_val)
    );

    assign w_is_alu    = is_alu_op(r_instr.opc);
    assign w_exec_last = (r_cnt == 4'(SETTLE_CYC - 1));
    assign w_rf_we     = (r_state == ST_WB) && !r_err && (r_instr.opc != OP_NOP);

    always_comb begin
        w_dec_err = 1'b0;
        if (w_is_alu) begin
            w_dec_err = !idx_ok(r_instr.rd, NUM_REGS) || !idx_ok(r_instr.rs1, NUM_REGS)
                     || !idx_ok(r_instr.rs2, NUM_REGS)
                     || (r_instr.opc == OP_DIV && w_rs2_val == '0);
        end else if (r_instr.opc == OP_LDI) begin
            w_dec_err = !idx_ok(r_instr.rd, NUM_REGS);
        end
    end

    // Only ADD/SUB trust the ALU's N/Z; logic/MUL/DIV flags are rebuilt from the result.
    always_comb begin
        w_flags_new = {2'b00, alu_result[15], alu_result == '0};
        if (r_instr.opc == OP_ADD || r_instr.opc == OP_SUB) begin
            w_flags_new = {alu_cout, alu_ovf, alu_n, alu_z};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid) w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = (w_is_alu && !w_dec_err) ? ST_EXEC : ST_WB;
            ST_EXEC:   if (w_exec_last) w_next_state = ST_WB;
            ST_WB:     w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        wb_err   = 1'b0;
        case (r_state)
            ST_IDLE: in_ready = !rst;
            ST_WB: begin
                wb_valid = 1'b1;
                wb_rd    = (r_instr.opc == OP_NOP) ? 3'd0 : r_instr.rd;
                wb_data  = r_wb_data;
                wb_err   = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr     <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_wb_data   <= '0;
            r_flags_cap <= '0;
            r_flags     <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_alu_sub   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_instr <= decode_instr(in_instr);
                        r_cnt   <= '0;
                    end
                end
                ST_DECODE: begin
                    r_err     <= w_dec_err;
                    r_wb_data <= (r_instr.opc == OP_LDI && !w_dec_err) ? {6'b0, r_instr.imm} : 16'd0;
                    if (w_is_alu && !w_dec_err) begin
                        r_alu_a   <= w_rs1_val;
                        r_alu_b   <= w_rs2_val;
                        r_alu_op  <= r_instr.opc;
                        r_alu_sub <= (r_instr.opc == OP_SUB);
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_exec_last) begin
                        r_wb_data   <= alu_result;
                        r_flags_cap <= w_flags_new;
                    end
                end
                ST_WB: begin
                    if (w_is_alu && !r_err) r_flags <= r_flags_cap;
                end
                default: ;
            endcase
        end
    end

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_op  = r_alu_op;
    assign alu_sub = r_alu_sub;
    assign flags   = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_seq
// Brief    : Self-checking bench for alu_issue_seq with a behavioural ALU and
//            an architectural register/flag model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_alu_issue_seq;

    localparam int S    = 4;
    localparam int NREG = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = '0;
    logic        in_ready;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_sub, alu_cout, alu_ovf, alu_n, alu_z;
    logic [2:0]  alu_op;
    logic        wb_valid, wb_err;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [3:0]  flags;

    logic [3:0]  junk = 4'h5;
    logic [15:0] m [8];
    logic [3:0]  mflags;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    alu_issue_seq #(.SETTLE_CYC(S), .NUM_REGS(NREG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_ovf(alu_ovf), .alu_n(alu_n), .alu_z(alu_z),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err), .flags(flags)
    );

    // Behavioural ALU: real flags for ADD/SUB, noise on the flag pins otherwise.
    function automatic logic [19:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] jf);
        logic [16:0] s;
        logic [15:0] r;
        logic [31:0] p;
        r = '0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                return {s[16], (a[15] == b[15]) && (r[15] != a[15]), r[15], r == 16'd0, r};
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                r = s[15:0];
                return {s[16], (a[15] != b[15]) && (r[15] != a[15]), r[15], r == 16'd0, r};
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin p = a * b; r = p[15:0]; end
            3'd5: r = (b == 16'd0) ? 16'hFFFF : a / b;
            default: r = '0;
        endcase
        return {jf, r};
    endfunction

    always @(posedge clk) junk <= 4'($urandom);
    always_comb {alu_cout, alu_ovf, alu_n, alu_z, alu_result} = alu_fn(alu_op, alu_a, alu_b, junk);

    function automatic logic [15:0] mk(input int opc, input int rd, input int rs1, input int rs2);
        return {3'(opc), 3'(rd), 3'(rs1), 3'(rs2), 4'b0};
    endfunction

    function automatic logic [15:0] mki(input int rd, input int imm);
        return {3'd6, 3'(rd), 10'(imm)};
    endfunction

    task automatic run_instr(input logic [15:0] ins, input bit presented, input bit hold_after,
                             input logic [15:0] next_ins);
        logic [2:0]  opc, rd, rs1, rs2, exp_rd;
        logic        is_alu, err, wr;
        logic [15:0] a, b, exp_data;
        logic [3:0]  exp_flags;
        logic [19:0] f;
        int          lat, n;
        bit          got;
        opc = ins[15:13]; rd = ins[12:10]; rs1 = ins[9:7]; rs2 = ins[6:4];
        is_alu = (opc <= 3'd5);
        a = m[rs1]; b = m[rs2];
        exp_flags = mflags; err = 1'b0; wr = 1'b0; exp_rd = rd; exp_data = '0; lat = 2;
        if (opc == 3'd7) begin
            exp_rd = 3'd0;
        end else if (opc == 3'd6) begin
            err = (rd >= NREG);
            if (!err) begin wr = 1'b1; exp_data = {6'b0, ins[9:0]}; end
        end else begin
            err = (rd >= NREG) || (rs1 >= NREG) || (rs2 >= NREG) || (opc == 3'd5 && b == 16'd0);
            if (!err) begin
                f = alu_fn(opc, a, b, 4'h0);
                exp_data = f[15:0]; wr = 1'b1; lat = S + 2;
                exp_flags = (opc <= 3'd1) ? f[19:16] : {2'b00, f[15], f[15:0] == 16'd0};
            end
        end

        if (!presented) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = ins;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL in_ready_idle ins=%h: got %b want 1", ins, in_ready);
        end
        @(posedge clk);
        n = 0; got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (hold_after) in_instr = next_ins;
                else begin in_valid = 1'b0; in_instr = 16'($urandom); end
            end
            got = (wb_valid === 1'b1);
        end
        if (!got || n != lat) begin
            n_err++; $display("FAIL latency ins=%h: got %0d cycles (seen=%0b) want %0d", ins, n, got, lat);
        end
        if (got) begin
            if (wb_rd !== exp_rd || wb_data !== exp_data || wb_err !== err) begin
                n_err++;
                $display("FAIL writeback ins=%h: got rd=%0d data=%h err=%b want rd=%0d data=%h err=%b",
                         ins, wb_rd, wb_data, wb_err, exp_rd, exp_data, err);
            end
            if (is_alu && !err &&
                (alu_a !== a || alu_b !== b || alu_op !== opc || alu_sub !== (opc == 3'd1))) begin
                n_err++;
                $display("FAIL alu_drive ins=%h: got a=%h b=%h op=%0d sub=%b want a=%h b=%h op=%0d sub=%b",
                         ins, alu_a, alu_b, alu_op, alu_sub, a, b, opc, opc == 3'd1);
            end
        end
        @(negedge clk);
        if (wb_valid !== 1'b0 || in_ready !== 1'b1 || flags !== exp_flags) begin
            n_err++;
            $display("FAIL post_wb ins=%h: got wb_valid=%b in_ready=%b flags=%b want 0 1 %b",
                     ins, wb_valid, in_ready, flags, exp_flags);
        end
        if (wr) m[rd] = exp_data;
        mflags = exp_flags;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) m[i] = '0;
        mflags = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({wb_valid, wb_err, wb_rd, wb_data, flags, alu_a, alu_b, alu_op, alu_sub} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got wb=%b/%b/%0d/%h flags=%b alu=%h/%h/%0d/%b want all 0",
                     wb_valid, wb_err, wb_rd, wb_data, flags, alu_a, alu_b, alu_op, alu_sub);
        end
        rst = 1'b0;
        @(negedge clk);
        if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_release: got in_ready=%b wb_valid=%b want 1 0", in_ready, wb_valid);
        end
    endtask

    task automatic test_directed();
        run_instr(mki(0, 5), 0, 0, 16'h0);
        run_instr(mki(1, 3), 0, 0, 16'h0);
        run_instr(mk(0, 2, 0, 1), 0, 0, 16'h0);     // ADD -> 8
        run_instr(mki(0, 0), 0, 0, 16'h0);
        run_instr(mki(1, 1), 0, 0, 16'h0);
        run_instr(mk(1, 2, 0, 1), 0, 0, 16'h0);     // SUB -> FFFF
        run_instr(mki(1, 0), 0, 0, 16'h0);
        run_instr(mk(5, 2, 0, 1), 0, 0, 16'h0);     // DIV by zero
        run_instr(mk(3, 3, 2, 0), 0, 0, 16'h0);     // reads r2 back
        run_instr(mki(7, 10'h3FF), 0, 0, 16'h0);
        run_instr(mk(0, 1, 6, 0), 0, 0, 16'h0);
        run_instr(16'hFFFF, 0, 0, 16'h0);           // NOP with junk fields
    endtask

    task automatic test_back_to_back();
        logic [15:0] q [3];
        q[0] = mki(4, 10'h12);
        q[1] = mk(0, 5, 4, 4);
        q[2] = mk(1, 0, 5, 4);
        run_instr(q[0], 0, 1, q[1]);
        run_instr(q[1], 1, 1, q[2]);
        run_instr(q[2], 1, 0, 16'h0);
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        for (int i = 0; i < NREG; i++) run_instr(mki(i, i * 37 + 1), 0, 0, 16'h0);
        run_instr(mk(0, 0, 1, 2), 0, 0, 16'h0);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = mk(4, 3, 1, 2);
        @(posedge clk);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({wb_valid, wb_err, wb_rd, wb_data, flags, alu_a, alu_b, alu_op, alu_sub} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_op: got wb=%b/%b/%0d/%h flags=%b alu=%h/%h/%0d/%b want all 0",
                     wb_valid, wb_err, wb_rd, wb_data, flags, alu_a, alu_b, alu_op, alu_sub);
        end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (wb_valid !== 1'b0) seen = 1'b1; end
        rst = 1'b0;
        repeat (S + 3) begin @(negedge clk); if (wb_valid !== 1'b0) seen = 1'b1; end
        if (seen) begin
            n_err++; $display("FAIL reset_abort_wb: got wb_valid pulse want none");
        end
        for (int i = 0; i < 8; i++) m[i] = '0;
        mflags = '0;
        run_instr(mk(0, 0, 0, 1), 0, 0, 16'h0);
        run_instr(mk(0, 0, 2, 3), 0, 0, 16'h0);
        run_instr(mk(0, 0, 4, 5), 0, 0, 16'h0);
    endtask

    task automatic test_random();
        logic [2:0]  opc, rd, rs1, rs2;
        logic [15:0] ins;
        for (int k = 0; k < 200; k++) begin
            opc = 3'($urandom_range(0, 7));
            rd  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            rs1 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            rs2 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            if (opc == 3'd6) ins = {opc, rd, 10'($urandom)};
            else ins = {opc, rd, rs1, rs2, 4'($urandom)};
            run_instr(ins, 0, 0, 16'h0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
